audio_dac: RTL and testbench
============================

AUDIO_DAC -- requirements
Module: audio_dac

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- CHANNELS, 2, number of independent output channels.
- WIDTH, 9, DAC resolution in bits; one PWM period is 2^WIDTH ticks.
- IN_WIDTH, 16, signed input sample width; IN_WIDTH >= WIDTH.

REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ce  input  1  tick enable; counters and modulators advance only when ce=1.
- mode  input  1  0 = PWM, 1 = first-order sigma-delta.
- sample_in  input  CHANNELS*IN_WIDTH  two's-complement samples; channel k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  the pending slot is empty.
- dac_out  output  CHANNELS  registered 1-bit modulator outputs.
- underrun  output  1  one-cycle pulse at a period wrap when no pending sample exists.

Function
REQ-003 SHALL convert each sample to offset binary by inverting its MSB, then take the top WIDTH bits as the level L, range 0 to 2^WIDTH-1.
REQ-004 SHALL keep a free-running period counter cnt of WIDTH bits:
- increments on ce;
- wraps from 2^WIDTH-1 to 0;
- the "wrap cycle" is the cycle in which ce=1 and cnt=2^WIDTH-1.
REQ-005 SHALL drive sample_ready = NOT pending_full (combinational).
REQ-006 SHALL, when sample_valid=1 and sample_ready=1, capture all CHANNELS levels into pending and set pending_full on the next edge.
REQ-007 SHALL ignore sample_valid while pending_full=1; the sample is not consumed and the source holds it.
REQ-008 SHALL, on a wrap cycle with pending_full=1:
- copy pending to the active levels;
- clear pending_full;
- sample_ready rises on the following cycle.
REQ-009 SHALL, on a wrap cycle with pending_full=0:
- keep the active levels unchanged;
- pulse underrun high for exactly one cycle.
REQ-010 SHALL, when an accept and a wrap occur in the same cycle with the slot empty:
- load the sample into pending, to be committed at the next wrap;
- assert underrun.
REQ-011 SHALL latch mode only on wrap cycles, so a mode change takes effect from the next period.
REQ-012 SHALL, in PWM mode, register dac_out[k] = (cnt < L_k):
- L=0 gives constant 0;
- L=2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH ticks.
REQ-013 SHALL, in sigma-delta mode, on each ce:
- update a WIDTH-bit accumulator per channel: acc <= acc + L_k, modulo 2^WIDTH;
- register dac_out[k] = carry out of that addition.
REQ-014 SHALL clear all sigma-delta accumulators on any wrap cycle where the latched mode changes.
REQ-015 SHALL hold dac_out, cnt and the accumulators when ce=0.

Reset
REQ-016 SHALL, while rst_n=0, asynchronously force the following, with no clock needed:
- cnt=0, all accumulators=0, active levels=0;
- pending_full=0, latched mode=0;
- dac_out=0, underrun=0.
REQ-017 SHALL drive sample_ready=1 during and after reset.
REQ-018 SHALL, when reset is applied mid-period, drop dac_out immediately and restart from cnt=0 after release.

Structure
REQ-019 SHALL place the following in shared package audio_pkg:
- the mode constants MODE_PWM=0 and MODE_SD=1;
- the offset-binary/level-extraction function.
REQ-020 SHALL implement per-channel logic in sub-module audio_dac_chan, instantiated CHANNELS times by generate:
- active level register;
- PWM comparator;
- sigma-delta accumulator;
- output register.
REQ-021 SHALL keep cnt, the handshake logic and the mode latch in audio_dac, shared by all channels.

Verification (CHANNELS=2, WIDTH=9, IN_WIDTH=16, ce=1 unless stated)
REQ-022 SHALL cover reset: rst_n=0 with no clock -> dac_out=00, sample_ready=1, underrun=0.
REQ-023 SHALL cover PWM duty: ch0=16'h0000 and ch1=16'h7FFF accepted, mode=0 -> after commit, ch0 is high 256/512 ticks and ch1 is high 511/512 ticks per period.
REQ-024 SHALL cover backpressure: two back-to-back samples -> first accepted; sample_ready=0 until the cycle after the wrap; second accepted then; committed one wrap later.
REQ-025 SHALL cover sigma-delta: mode=1 with level 128 -> exactly 128 ones per 512 ticks, one pulse every 4 ticks.
REQ-026 SHALL cover underrun: no sample offered across a wrap -> underrun high for one cycle; duty unchanged.
REQ-027 SHALL cover mid-period reset and ce gating:
- rst_n=0 at cnt=100 -> dac_out=0 at once and cnt=0 after release;
- ce held 0 for 50 cycles -> cnt and dac_out frozen.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio DAC: modulation mode encodings
// and the sample-to-level conversion used when a sample is accepted.
package audio_pkg;

    localparam logic MODE_PWM = 1'b0;
    localparam logic MODE_SD  = 1'b1;

    // Two's-complement sample -> unsigned modulator level.
    // Inverting the sign bit gives offset binary (most negative -> 0,
    // most positive -> all ones). The top 'width' bits of that become the
    // level. Samples are passed zero-extended in a 64-bit container, so
    // in_width is limited to 64.
    function automatic logic [31:0] level_of(
        input logic [63:0] sample,
        input int          in_width,
        input int          width
    );
        logic [63:0] offset_bin;
        logic [63:0] mask;
        offset_bin = sample ^ (64'd1 << (in_width - 1));
        offset_bin = offset_bin >> (in_width - width);
        mask       = (64'd1 << width) - 64'd1;
        return 32'(offset_bin & mask);
    endfunction

endpackage

// File: rtl/audio_dac_chan.sv
// One DAC output channel: holds the active level and produces either a PWM
// or a first-order sigma-delta bitstream from it, registered onto dac_o.
module audio_dac_chan
    import audio_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] level_i,
    input  logic             acc_clr_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             dac_o
);

    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             dac_q;
    logic             dac_d;
    logic [WIDTH:0]   sum;

    // The carry out of this sum is the sigma-delta output bit.
    assign sum = {1'b0, acc_q} + {1'b0, level_q};

    // Next-state for level, accumulator and output bit.
    always_comb begin
        level_d = level_q;
        acc_d   = acc_q;
        dac_d   = dac_q;
        if (load_i) begin
            level_d = level_i;
        end
        if (ce_i) begin
            if (mode_i == MODE_SD) begin
                acc_d = sum[WIDTH-1:0];
                dac_d = sum[WIDTH];
            end else begin
                dac_d = (cnt_i < level_q);
            end
        end
        // A mode switch restarts the modulator from a clean accumulator.
        if (acc_clr_i) begin
            acc_d = '0;
        end
    end

    // Channel state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            acc_q   <= '0;
            dac_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            acc_q   <= acc_d;
            dac_q   <= dac_d;
        end
    end

    assign dac_o = dac_q;

endmodule

// File: rtl/audio_dac.sv
// Multi-channel 1-bit audio DAC. Owns the shared period counter, the
// single-slot sample handshake and the per-period mode latch; each channel's
// modulator lives in audio_dac_chan.
module audio_dac
    import audio_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 9,
    parameter int IN_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ce,
    input  logic                         mode,
    input  logic [CHANNELS*IN_WIDTH-1:0] sample_in,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    output logic [CHANNELS-1:0]          dac_out,
    output logic                         underrun
);

    logic [WIDTH-1:0]          cnt_q;
    logic [WIDTH-1:0]          cnt_d;
    logic                      pend_full_q;
    logic                      pend_full_d;
    logic [CHANNELS*WIDTH-1:0] pend_q;
    logic [CHANNELS*WIDTH-1:0] pend_d;
    logic [CHANNELS*WIDTH-1:0] level_in;
    logic                      mode_q;
    logic                      mode_d;
    logic                      underrun_q;
    logic                      underrun_d;
    logic                      wrap;
    logic                      accept;
    logic                      commit;
    logic                      acc_clr;

    // Last tick of a period: the only point where levels and mode change.
    assign wrap   = ce && (cnt_q == {WIDTH{1'b1}});
    assign accept = sample_valid && !pend_full_q;
    assign commit = wrap && pend_full_q;
    assign acc_clr = wrap && (mode != mode_q);

    assign sample_ready = !pend_full_q;
    assign underrun     = underrun_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign level_in[gi*WIDTH +: WIDTH] = WIDTH'(level_of(
                64'(sample_in[gi*IN_WIDTH +: IN_WIDTH]), IN_WIDTH, WIDTH));

            audio_dac_chan #(
                .WIDTH (WIDTH)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .ce_i      (ce),
                .mode_i    (mode_q),
                .load_i    (commit),
                .level_i   (pend_q[gi*WIDTH +: WIDTH]),
                .acc_clr_i (acc_clr),
                .cnt_i     (cnt_q),
                .dac_o     (dac_out[gi])
            );
        end
    endgenerate

    // Next-state for counter, pending slot, mode latch and underrun flag.
    // accept and commit are mutually exclusive: accept needs an empty slot,
    // commit needs a full one.
    always_comb begin
        cnt_d       = cnt_q;
        pend_full_d = pend_full_q;
        pend_d      = pend_q;
        mode_d      = mode_q;
        underrun_d  = 1'b0;
        if (ce) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (wrap) begin
            mode_d     = mode;
            underrun_d = !pend_full_q;
        end
        if (commit) begin
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = level_in;
            pend_full_d = 1'b1;
        end
    end

    // Shared control registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            mode_q      <= MODE_PWM;
            underrun_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
            mode_q      <= mode_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_audio_dac.sv
// Bench for audio_dac: integer-arithmetic reference model compared every
// cycle, plus directed duty/handshake/reset scenarios with literal counts.
module tb_audio_dac;

    localparam int CH = 2;
    localparam int W  = 9;
    localparam int IW = 16;
    localparam int P  = 1 << W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             ce = 1'b1;
    logic             mode = 1'b0;
    logic [CH*IW-1:0] sample_in = '0;
    logic             sample_valid = 1'b0;
    logic             sample_ready;
    logic [CH-1:0]    dac_out;
    logic             underrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    audio_dac #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .IN_WIDTH (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ce           (ce),
        .mode         (mode),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .dac_out      (dac_out),
        .underrun     (underrun)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Level as plain arithmetic: shift the signed range up to unsigned,
    // then keep the top W bits.
    function automatic int lvl_of(input logic [IW-1:0] s);
        int v;
        v = (int'(s) + (1 << (IW - 1))) % (1 << IW);
        return v >> (IW - W);
    endfunction

    // ---------------- reference model ----------------
    int     m_cnt = 0;
    bit     m_full = 0;
    int     m_pend [CH];
    int     m_lvl  [CH];
    bit     m_mode = 0;
    longint m_tot  [CH];
    bit     m_dac  [CH];
    bit     m_under = 0;
    bit     m_wrap;
    bit     m_was_full;
    longint m_before;

    initial begin
        for (int k = 0; k < CH; k++) begin
            m_pend[k] = 0; m_lvl[k] = 0; m_tot[k] = 0; m_dac[k] = 0;
        end
    end

    // PWM: high while tick position < level. Sigma-delta: a one whenever
    // the running total of levels crosses another multiple of P.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_full = 0; m_mode = 0; m_under = 0;
            for (int k = 0; k < CH; k++) begin
                m_lvl[k] = 0; m_tot[k] = 0; m_dac[k] = 0;
            end
        end else begin
            m_wrap = ce && (m_cnt == P - 1);
            m_was_full = m_full;
            if (ce) begin
                for (int k = 0; k < CH; k++) begin
                    if (!m_mode) begin
                        m_dac[k] = (m_cnt < m_lvl[k]);
                    end else begin
                        m_before = m_tot[k] / P;
                        m_tot[k] = m_tot[k] + m_lvl[k];
                        m_dac[k] = ((m_tot[k] / P) != m_before);
                    end
                end
            end
            m_under = m_wrap && !m_was_full;
            if (m_wrap) begin
                if (mode != m_mode) begin
                    for (int k = 0; k < CH; k++) m_tot[k] = 0;
                end
                m_mode = mode;
                if (m_was_full) begin
                    for (int k = 0; k < CH; k++) m_lvl[k] = m_pend[k];
                    m_full = 0;
                end
            end
            if (sample_valid && !m_was_full) begin
                for (int k = 0; k < CH; k++) m_pend[k] = lvl_of(sample_in[k*IW +: IW]);
                m_full = 1;
            end
            if (ce) m_cnt = (m_cnt + 1) % P;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        for (int k = 0; k < CH; k++) chk($sformatf("dac_out[%0d]", k), dac_out[k], m_dac[k]);
        chk("underrun", underrun, m_under);
        chk("sample_ready", sample_ready, !m_full);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [CH*IW-1:0] s, output int waited);
        bool_loop: begin
            sample_in = s;
            sample_valid = 1'b1;
            waited = 0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (sample_ready) disable bool_loop;
                waited++;
            end
            chk("send_timeout", 0, 1);
        end
        @(posedge clk);
        #1 sample_valid = 1'b0;
    endtask

    task automatic count_window(input int n, output int o0, output int o1,
                                output int und, output int bad4);
        o0 = 0; o1 = 0; und = 0; bad4 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dac_out[0]) o0++;
            if (dac_out[1]) begin
                o1++;
                if ((i % 4) != 3) bad4++;
            end
            if (underrun) und++;
        end
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (m_cnt == target) return;
        end
        chk("wait_cnt_timeout", 0, 1);
    endtask

    int w, o0, o1, und, bad4;

    initial begin
        // Reset asserted with no clock edge yet.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_dac_out", dac_out, 0);
        chk("rst_sample_ready", sample_ready, 1);
        chk("rst_underrun", underrun, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Backpressure: A accepted at once; B waits until the cycle after the wrap.
        send({16'h7FFF, 16'h0000}, w);
        chk("wait_A", w, 0);
        send({16'hC000, 16'h8000}, w);
        chk("wait_B", w, 511);

        // Period with A active: ch0 level 256, ch1 level 511; B commits at its wrap.
        count_window(P, o0, o1, und, bad4);
        chk("pwm_A_ch0", o0, 256);
        chk("pwm_A_ch1", o1, 511);
        chk("pwm_A_underrun", und, 0);

        // Period with B active: ch0 level 0, ch1 level 128; wrap with empty slot.
        count_window(P, o0, o1, und, bad4);
        chk("pwm_B_ch0", o0, 0);
        chk("pwm_B_ch1", o1, 128);
        chk("underrun_pulses_1", und, 1);

        // Request sigma-delta; it only takes effect from the next period.
        mode = 1'b1;
        count_window(P, o0, o1, und, bad4);
        chk("pwm_hold_ch1", o1, 128);
        chk("underrun_pulses_2", und, 1);

        // Sigma-delta with level 128: 128 ones, one every fourth tick.
        mode = 1'b0;
        count_window(P, o0, o1, und, bad4);
        chk("sd_ch1_ones", o1, 128);
        chk("sd_ch1_spacing", bad4, 0);
        chk("sd_ch0_ones", o0, 0);

        // Mid-period reset at cnt=100 in PWM with ch1 level 128.
        wait_cnt(100);
        chk("pre_reset_dac1", dac_out[1], 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_dac_out", dac_out, 0);
        chk("mid_reset_ready", sample_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Counter restarted at 0: second sample waits exactly 511 cycles again.
        send({16'h8000, 16'h0000}, w);
        chk("post_reset_wait_C", w, 0);
        send({16'h8000, 16'h0000}, w);
        chk("post_reset_wait_D", w, 511);

        // ce gating: freeze at cnt=254 with ch0 level 256.
        wait_cnt(254);
        ce = 1'b0;
        count_window(50, o0, o1, und, bad4);
        chk("freeze_ch0_ones", o0, 50);
        chk("freeze_underrun", und, 0);
        ce = 1'b1;
        count_window(3, o0, o1, und, bad4);
        chk("resume_ch0_ones", o0, 2);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
